// File: rtl/fetch_decode_skid_reg.sv
// fetch_decode_skid_reg
//   Fetch-to-decode pipeline register with a valid/ready handshake and a
//   two-entry skid buffer. It carries instruction, PC and PC+4 from fetch to
//   decode. ReadyF comes from registered state only, which cuts the
//   combinational path from a decode stall back to fetch.
//
// Ports
//   CLK, RST            clock; asynchronous active-high reset
//   ValidF/ReadyF       fetch-side handshake
//   InstrF/PCF/PCPlus4F fetch-side payload
//   FlushD              kill held and incoming beats; InstrD goes to NOP
//   ValidD/ReadyD       decode-side handshake (ReadyD=0 stalls)
//   InstrD/PCD/PCPlus4D decode-side payload; InstrD is NOP_INSTR whenever ValidD=0
//   Occupancy           number of valid entries held (0..2)
//   StallCnt/BubbleCnt  saturating stall and bubble cycle counters

module fetch_decode_skid_reg #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013),
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ValidF,
  input  logic [XLEN-1:0]  InstrF,
  input  logic [XLEN-1:0]  PCF,
  input  logic [XLEN-1:0]  PCPlus4F,
  output logic             ReadyF,
  input  logic             FlushD,
  output logic             ValidD,
  output logic [XLEN-1:0]  InstrD,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  input  logic             ReadyD,
  output logic [1:0]       Occupancy,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] BubbleCnt
);

  // Encoding equals the number of held entries so it doubles as Occupancy.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e r_state, w_state_next;

  logic [XLEN-1:0] r_instr, r_pc, r_pc4;
  logic [XLEN-1:0] r_skid_instr, r_skid_pc, r_skid_pc4;
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

  logic w_accept;
  logic w_xfer;
  logic w_load_main_in;    // main <= fetch input
  logic w_load_main_skid;  // main <= skid
  logic w_load_skid;       // skid <= fetch input
  logic w_clr_instr;       // main instruction <= NOP (entry leaves, nothing replaces it)

  assign ReadyF    = (r_state != StFull);
  assign ValidD    = (r_state != StEmpty);
  assign Occupancy = r_state;
  assign InstrD    = r_instr;
  assign PCD       = r_pc;
  assign PCPlus4D  = r_pc4;
  assign StallCnt  = r_stall_cnt;
  assign BubbleCnt = r_bubble_cnt;

  assign w_accept = ValidF & ReadyF;
  assign w_xfer   = ValidD & ReadyD;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_clr_instr      = 1'b0;
    if (FlushD) begin
      // Flush wins over everything, including a beat accepted this cycle.
      w_state_next = StEmpty;
      w_clr_instr  = 1'b1;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            w_load_main_in = 1'b1;
            w_state_next   = StOne;
          end
        end
        StOne: begin
          if (w_accept && w_xfer) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_load_skid  = 1'b1;
            w_state_next = StFull;
          end else if (w_xfer) begin
            w_clr_instr  = 1'b1;
            w_state_next = StEmpty;
          end
        end
        StFull: begin
          if (w_xfer) begin
            w_load_main_skid = 1'b1;
            w_state_next     = StOne;
          end
        end
        default: begin
          w_state_next = StEmpty;
          w_clr_instr  = 1'b1;
        end
      endcase
    end
  end

  // Main register; PC fields keep their last value when the entry drains.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pc4   <= '0;
    end else if (w_load_main_in) begin
      r_instr <= InstrF;
      r_pc    <= PCF;
      r_pc4   <= PCPlus4F;
    end else if (w_load_main_skid) begin
      r_instr <= r_skid_instr;
      r_pc    <= r_skid_pc;
      r_pc4   <= r_skid_pc4;
    end else if (w_clr_instr) begin
      r_instr <= NOP_INSTR;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_pc4   <= '0;
    end else if (w_load_skid) begin
      r_skid_instr <= InstrF;
      r_skid_pc    <= PCF;
      r_skid_pc4   <= PCPlus4F;
    end
  end

  // Counters use the pre-flush ValidD, so they behave the same in a flush cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (ValidD && !ReadyD && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (!ValidD && ReadyD && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_skid_reg.sv
module tb_fetch_decode_skid_reg;

  localparam int          XLEN  = 32;
  localparam int          CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam int          VW    = 1 + 3 * XLEN + 2 + 1 + 2 * CNT_W;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             ValidF = 1'b0;
  logic [XLEN-1:0]  InstrF = '0, PCF = '0, PCPlus4F = '0;
  logic             ReadyF;
  logic             FlushD = 1'b0;
  logic             ValidD;
  logic [XLEN-1:0]  InstrD, PCD, PCPlus4D;
  logic             ReadyD = 1'b0;
  logic [1:0]       Occupancy;
  logic [CNT_W-1:0] StallCnt, BubbleCnt;

  fetch_decode_skid_reg #(
    .XLEN     (XLEN),
    .NOP_INSTR(NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ValidF   (ValidF),
    .InstrF   (InstrF),
    .PCF      (PCF),
    .PCPlus4F (PCPlus4F),
    .ReadyF   (ReadyF),
    .FlushD   (FlushD),
    .ValidD   (ValidD),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ReadyD   (ReadyD),
    .Occupancy(Occupancy),
    .StallCnt (StallCnt),
    .BubbleCnt(BubbleCnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an in-order FIFO of at most two beats plus the last PCs shown.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } beat_t;

  beat_t            mq[$];
  logic [XLEN-1:0]  m_pc, m_pc4;
  logic [CNT_W-1:0] m_stall, m_bubble;

  logic [VW-1:0] obs;
  assign obs = {ValidD, InstrD, PCD, PCPlus4D, Occupancy, ReadyF, StallCnt, BubbleCnt};

  function automatic logic [VW-1:0] exp_vec();
    logic [XLEN-1:0] ins;
    logic            v;
    v   = (mq.size() != 0);
    ins = NOP;
    if (v) ins = mq[0].instr;
    return {v, ins, m_pc, m_pc4, 2'(mq.size()), (mq.size() < 2), m_stall, m_bubble};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc     = '0;
    m_pc4    = '0;
    m_stall  = '0;
    m_bubble = '0;
  endtask

  task automatic model_update();
    bit    v, acc, xf;
    beat_t b;
    v   = (mq.size() != 0);
    acc = ValidF && (mq.size() < 2);
    xf  = v && ReadyD;
    if (v && !ReadyD && m_stall != CMAX) m_stall = m_stall + 1'b1;
    if (!v && ReadyD && m_bubble != CMAX) m_bubble = m_bubble + 1'b1;
    if (FlushD) begin
      mq.delete();
    end else begin
      if (xf) void'(mq.pop_front());
      if (acc) begin
        b.instr = InstrF;
        b.pc    = PCF;
        b.pc4   = PCPlus4F;
        mq.push_back(b);
      end
    end
    if (mq.size() != 0) begin
      m_pc  = mq[0].pc;
      m_pc4 = mq[0].pc4;
    end
  endtask

  // One clock: advance the model with the current inputs, then the DUT.
  task automatic tick();
    model_update();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit rdy, input bit fl);
    ValidF   = v;
    InstrF   = ins;
    PCF      = pc;
    PCPlus4F = pc + 32'd4;
    ReadyD   = rdy;
    FlushD   = fl;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0);
    #2;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [VW-1:0] want;
    do_reset();
    want = {1'b0, NOP, 32'h0, 32'h0, 2'd0, 1'b1, {CNT_W{1'b0}}, {CNT_W{1'b0}}};
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL reset_values: got %h want %h", obs, want);
    end
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_model: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_streaming();
    logic [31:0] want;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h00100093 + 32'(k), 32'(4 * k), 1, 0);
      tick();
      want = 32'h00100093 + 32'(k);
      n_checks++;
      if (InstrD !== want || ValidD !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_instr k=%0d: got %h/%b want %h/1", k, InstrD, ValidD, want);
      end
      n_checks++;
      if (ReadyF !== 1'b1 || Occupancy > 2'd1 || StallCnt !== '0) begin
        n_fail++;
        $display("FAIL stream_flow k=%0d: readyf=%b occ=%0d stall=%0d want 1,<=1,0",
                 k, ReadyF, Occupancy, StallCnt);
      end
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL stream_model k=%0d: got %h want %h", k, obs, exp_vec());
      end
    end
    drive(0, 32'h0, 32'h0, 1, 0);
    tick();
  endtask

  task automatic test_skid_fill();
    logic [31:0] a, b, c;
    logic [31:0] got[$];
    bit          c_acc;
    a = 32'hA0A00001;
    b = 32'hA0A00002;
    c = 32'hA0A00003;
    do_reset();
    drive(1, a, 32'h100, 0, 0);
    tick();
    drive(1, b, 32'h104, 0, 0);
    tick();
    drive(1, c, 32'h108, 0, 0);
    tick();
    n_checks++;
    if (Occupancy !== 2'd2 || ReadyF !== 1'b0 || InstrD !== a) begin
      n_fail++;
      $display("FAIL skid_full: occ=%0d readyf=%b instr=%h want 2,0,%h",
               Occupancy, ReadyF, InstrD, a);
    end
    tick();
    n_checks++;
    if (StallCnt !== 4'd3 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL skid_stall: stall=%0d want 3; got %h want %h", StallCnt, obs, exp_vec());
    end
    ReadyD = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (ValidD) got.push_back(InstrD);
      c_acc = ValidF && ReadyF;
      tick();
      if (c_acc) ValidF = 1'b0;
    end
    n_checks++;
    if (got.size() != 3) begin
      n_fail++;
      $display("FAIL skid_count: got %0d beats want 3", got.size());
    end else begin
      n_checks++;
      if (got[0] !== a || got[1] !== b || got[2] !== c) begin
        n_fail++;
        $display("FAIL skid_order: got %h %h %h want %h %h %h", got[0], got[1], got[2], a, b, c);
      end
    end
    n_checks++;
    if (StallCnt !== 4'd3 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL skid_drain: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_flush_full();
    bit seen_dead;
    do_reset();
    drive(1, 32'h00000111, 32'h40, 0, 0);
    tick();
    drive(1, 32'h00000222, 32'h44, 0, 0);
    tick();
    n_checks++;
    if (Occupancy !== 2'd2 || PCD !== 32'h40) begin
      n_fail++;
      $display("FAIL flush_setup: occ=%0d pcd=%h want 2,40", Occupancy, PCD);
    end
    drive(1, 32'h0000DEAD, 32'h80, 0, 1);
    tick();
    drive(0, 32'h0, 32'h0, 1, 0);
    n_checks++;
    if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h40 || Occupancy !== 2'd0
        || ReadyF !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: v=%b instr=%h pcd=%h occ=%0d rf=%b want 0,%h,40,0,1",
               ValidD, InstrD, PCD, Occupancy, ReadyF, NOP);
    end
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL flush_model: got %h want %h", obs, exp_vec());
    end
    seen_dead = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (InstrD === 32'h0000DEAD) seen_dead = 1;
    end
    n_checks++;
    if (seen_dead) begin
      n_fail++;
      $display("FAIL flush_discard: got DEAD on output want never");
    end
  endtask

  task automatic test_accept_xfer();
    do_reset();
    drive(1, 32'h00500513, 32'h200, 1, 0);
    tick();
    drive(1, 32'h00600613, 32'h204, 1, 0);
    tick();
    n_checks++;
    if (Occupancy !== 2'd1 || InstrD !== 32'h00600613 || PCD !== 32'h204) begin
      n_fail++;
      $display("FAIL one_replace: occ=%0d instr=%h pcd=%h want 1,00600613,204",
               Occupancy, InstrD, PCD);
    end
    drive(0, 32'h0, 32'h0, 1, 0);
    tick();
    n_checks++;
    if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h204 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL one_drain: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 32'h00700713, 32'h300, 0, 0);
    tick();
    drive(0, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (StallCnt !== CMAX || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL stall_saturate: stall=%0d want %0d; got %h want %h",
               StallCnt, CMAX, obs, exp_vec());
    end
    ReadyD = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    n_checks++;
    if (BubbleCnt !== CMAX || StallCnt !== CMAX) begin
      n_fail++;
      $display("FAIL bubble_saturate: bubble=%0d stall=%0d want %0d,%0d",
               BubbleCnt, StallCnt, CMAX, CMAX);
    end
  endtask

  task automatic test_async_reset();
    logic [VW-1:0] want;
    do_reset();
    drive(1, 32'h00800813, 32'h400, 0, 0);
    tick();
    drive(1, 32'h00900913, 32'h404, 0, 0);
    tick();
    drive(1, 32'h00A00A13, 32'h408, 0, 0);
    tick();
    n_checks++;
    if (Occupancy !== 2'd2 || StallCnt === '0) begin
      n_fail++;
      $display("FAIL areset_setup: occ=%0d stall=%0d want 2,>0", Occupancy, StallCnt);
    end
    #2;
    RST = 1'b1;
    #1;
    want = {1'b0, NOP, 32'h0, 32'h0, 2'd0, 1'b1, {CNT_W{1'b0}}, {CNT_W{1'b0}}};
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL areset_immediate: got %h want %h", obs, want);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    drive(1, 32'h00B00B13, 32'h500, 1, 0);
    tick();
    n_checks++;
    if (ValidD !== 1'b1 || InstrD !== 32'h00B00B13 || obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL areset_first_accept: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        bad++;
        if (bad < 10) $display("FAIL random cyc=%0d: got %h want %h", i, obs, exp_vec());
      end
      drive($urandom_range(0, 3) != 0, $urandom, $urandom & 32'hFFFFFFFC,
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      tick();
    end
    drive(0, 32'h0, 32'h0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid_fill();
    test_flush_full();
    test_accept_xfer();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
